// File: rtl/nav_pkg.sv
// Shared constants, state encoding and axis slice helpers for the autopilot.
`ifndef NAV_PKG_SV
`define NAV_PKG_SV

// Axis slices of a packed {Z,Y,X} bus with k bits per axis.
`define NAV_X(bus, k) bus[(k)-1:0]
`define NAV_Y(bus, k) bus[2*(k)-1:(k)]
`define NAV_Z(bus, k) bus[3*(k)-1:2*(k)]

package nav_pkg;

  // Velocity block mode (one-hot).
  localparam logic [3:0] MODE_ZERO    = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  // Position block mode (one-hot).
  localparam logic [3:0] POS_RESET  = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_JUMP   = 4'b0100;

  typedef enum logic [2:0] {
    ST_ZERO   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PLAN   = 3'd2,
    ST_JUMP   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CRUISE = 3'd5,
    ST_DONE   = 3'd6
  } nav_state_e;

endpackage

`endif

// File: rtl/nav_autopilot_if.sv
// Waypoint handshake plus the Velocity/Position command and feedback bundle.
// Handshake: a target transfers on a rising clk edge where tgt_valid and
// tgt_ready are both high; tgt_pos and jump_en are sampled on that edge only.
interface nav_autopilot_if #(
  parameter int K = 16
);
  logic         tgt_valid;
  logic         tgt_ready;
  logic [3*K-1:0] tgt_pos;
  logic         jump_en;
  logic         abort;
  logic [3*K-1:0] pos_in;
  logic [3:0]   mode;
  logic [3:0]   pos_mode;
  logic [3*K-1:0] speed;
  logic [3*K-1:0] jump_position;
  logic         arrived;
  logic         fault;
  logic         busy;

  // Mission side: offers waypoints, returns position, observes commands.
  modport master (
    output tgt_valid, tgt_pos, jump_en, abort, pos_in,
    input  tgt_ready, mode, pos_mode, speed, jump_position, arrived, fault, busy
  );

  // Autopilot side.
  modport slave (
    input  tgt_valid, tgt_pos, jump_en, abort, pos_in,
    output tgt_ready, mode, pos_mode, speed, jump_position, arrived, fault, busy
  );
endinterface

// File: rtl/nav_axis_step.sv
// One axis of the planner: signed shortest-path delta, saturated distance
// and a speed step clamped to MAX_STEP so the axis never overshoots.
module nav_axis_step #(
  parameter int K        = 16,
  parameter int MAX_STEP = 4
) (
  input  logic [K-1:0] tgt_i,
  input  logic [K-1:0] pos_i,
  output logic [K-1:0] step_o,
  output logic [K-1:0] dist_o,
  output logic         at_target_o
);

  localparam logic [K-1:0] MOST_NEG = {1'b1, {(K-1){1'b0}}};
  localparam logic [K-1:0] MAX_MAG  = {1'b0, {(K-1){1'b1}}};
  localparam logic [K-1:0] STEP_K   = K'(MAX_STEP);

  logic [K-1:0] delta;
  logic [K-1:0] mag;
  logic         neg;

  // Wrapped delta read as signed; the most-negative value has no positive
  // twin, so its magnitude saturates.
  always_comb begin
    delta  = tgt_i - pos_i;
    neg    = delta[K-1];
    dist_o = delta;
    if (delta == MOST_NEG) begin
      dist_o = MAX_MAG;
    end else if (neg) begin
      dist_o = '0 - delta;
    end
    mag         = (dist_o < STEP_K) ? dist_o : STEP_K;
    step_o      = neg ? ('0 - mag) : mag;
    at_target_o = (delta == '0);
  end

endmodule

// File: rtl/nav_autopilot.sv
// Waypoint autopilot: accepts a 3-axis target, then either jumps or cruises
// toward it, commanding the Velocity and Position blocks every cycle.
module nav_autopilot
  import nav_pkg::*;
#(
  parameter int K           = 16,
  parameter int MAX_STEP    = 4,
  parameter int JUMP_THRESH = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  nav_autopilot_if.slave bus,
  output nav_state_e dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [K-1:0]  THRESH_K  = K'(JUMP_THRESH);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  nav_state_e      state_q, state_d;
  logic [3*K-1:0]  tgt_q, tgt_d;
  logic            jen_q, jen_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3*K-1:0]  pos_w;
  logic [K-1:0]    step_x, step_y, step_z;
  logic [K-1:0]    dist_x, dist_y, dist_z;
  logic            at_x, at_y, at_z;
  logic            all_at, any_far;

  logic            ready;
  logic [3:0]      mode, pos_mode;
  logic [3*K-1:0]  speed;
  logic            arrived, fault;

  assign pos_w = bus.pos_in;

  nav_axis_step #(.K(K), .MAX_STEP(MAX_STEP)) u_x (
    .tgt_i(`NAV_X(tgt_q, K)), .pos_i(`NAV_X(pos_w, K)),
    .step_o(step_x), .dist_o(dist_x), .at_target_o(at_x)
  );
  nav_axis_step #(.K(K), .MAX_STEP(MAX_STEP)) u_y (
    .tgt_i(`NAV_Y(tgt_q, K)), .pos_i(`NAV_Y(pos_w, K)),
    .step_o(step_y), .dist_o(dist_y), .at_target_o(at_y)
  );
  nav_axis_step #(.K(K), .MAX_STEP(MAX_STEP)) u_z (
    .tgt_i(`NAV_Z(tgt_q, K)), .pos_i(`NAV_Z(pos_w, K)),
    .step_o(step_z), .dist_o(dist_z), .at_target_o(at_z)
  );

  assign all_at  = at_x & at_y & at_z;
  assign any_far = (dist_x > THRESH_K) | (dist_y > THRESH_K) | (dist_z > THRESH_K);

  // State, target latch, jump permission latch and cruise timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ZERO;
      tgt_q   <= '0;
      jen_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      jen_q   <= jen_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and all command outputs; abort wins over every other exit.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    jen_d    = jen_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    mode     = MODE_ZERO;
    pos_mode = POS_NORMAL;
    speed    = '0;
    arrived  = 1'b0;
    fault    = 1'b0;
    case (state_q)
      ST_ZERO: begin
        pos_mode = POS_RESET;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_pos;
          jen_d   = bus.jump_en;
          state_d = ST_PLAN;
        end
      end
      ST_PLAN: begin
        if (bus.abort) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else if (all_at) begin
          state_d = ST_DONE;
        end else if (jen_q && any_far) begin
          state_d = ST_JUMP;
        end else begin
          cnt_d   = '0;
          state_d = ST_CRUISE;
        end
      end
      ST_JUMP: begin
        if (bus.abort) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pos_mode = POS_JUMP;
          mode     = MODE_ATTACK;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else if (all_at) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_CRUISE;
        end
      end
      ST_CRUISE: begin
        mode = MODE_ATTACK;
        if (bus.abort) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else if (all_at) begin
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          fault   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          speed   = {step_z, step_y, step_x};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        arrived = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_ZERO;
    endcase
  end

  assign bus.tgt_ready     = ready;
  assign bus.mode          = mode;
  assign bus.pos_mode      = pos_mode;
  assign bus.speed         = speed;
  assign bus.jump_position = tgt_q;
  assign bus.arrived       = arrived;
  assign bus.fault         = fault;
  assign bus.busy          = (state_q != ST_IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: doc/nav_autopilot.md
Name: nav_autopilot

Overview:
- Command-side initiator for the Velocity/Position datapath. Accepts a 3-axis target waypoint over a valid/ready handshake and drives mode, pos_mode, speed and jump_position each cycle until the fed-back position equals the target.
- Sits between the mission/command logic and the Velocity + Position blocks. Position's registered output returns as pos_in.

Parameters:
- k, 16, bits per axis. All 3-axis buses are {Z,Y,X}, with X in [k-1:0].
- MAX_STEP, 4, maximum per-axis speed magnitude per cycle in sublight.
- JUMP_THRESH, 64, jump when any axis |distance| exceeds this and jump_en=1.
- TIMEOUT, 255, maximum CRUISE cycles per waypoint before fault. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tgt_valid  in  1  target waypoint offered
- tgt_ready  out  1  autopilot can accept a target
- tgt_pos  in  3k  target {Z,Y,X}, unsigned mod 2^k
- jump_en  in  1  permit jump for this waypoint; sampled with the handshake
- abort  in  1  abandon the current waypoint
- pos_in  in  3k  current position from Position
- mode  out  4  one-hot Velocity mode: 0001 zero, 0010 attack
- pos_mode  out  4  one-hot Position mode: 0001 reset, 0010 normal, 0100 jump
- speed  out  3k  per-axis speed, two's complement
- jump_position  out  3k  latched target
- arrived  out  1  one-cycle pulse when the waypoint is reached
- fault  out  1  one-cycle pulse on timeout or abort
- busy  out  1  high in every state except IDLE

Behaviour:
- States: ZERO, IDLE, PLAN, JUMP, SETTLE, CRUISE, DONE. State, the target latch, the jump_en latch and the timeout counter are registered. Outputs are combinational from state, latches and pos_in. pos_in is a register output, so there is no loop.
- Async reset (rst_n=0): state=ZERO, target latch=0, counter=0, arrived=fault=0.
- ZERO: one cycle. pos_mode=0001, mode=0001, speed=0. Next state IDLE.
- IDLE: tgt_ready=1, pos_mode=0010, mode=0001 (velocity 0, position holds). When tgt_valid=1, latch tgt_pos and jump_en and go to PLAN. tgt_ready=0 in all other states; offers there are not accepted.
- Per-axis delta d = tgt - pos mod 2^k, read as signed k-bit. Dist = |d|. The most-negative value saturates to 2^(k-1)-1.
- PLAN: one cycle, zero speed, pos_mode=0010.
  - If all axes have d=0: go to DONE.
  - Else if jump_en and any Dist > JUMP_THRESH: go to JUMP.
  - Else: go to CRUISE and clear the counter.
- JUMP: one cycle. pos_mode=0100, mode=0010, jump_position=target. Next state SETTLE.
- SETTLE: one cycle, pos_mode=0010, mode=0001. Compare pos_in against the target: if equal go to DONE, else go to CRUISE.
- CRUISE: pos_mode=0010, mode=0010 (attack, divisor 1, so velocity = speed). Per axis, speed = sign(d) * min(Dist, MAX_STEP); speed is 0 when d=0. This never overshoots.
  - When all d=0, go to DONE (speed is 0 that cycle).
  - The counter increments each CRUISE cycle. When counter reaches TIMEOUT, pulse fault and go to IDLE.
- DONE: arrived=1 for one cycle, zero speed. Next state IDLE.
- abort=1 in PLAN, JUMP, SETTLE or CRUISE: speed is forced to 0 that cycle, fault pulses, and the next state is IDLE. abort is ignored in ZERO, IDLE and DONE.
- Wrap-around: the shortest signed path is taken modulo 2^k. Position arithmetic wraps identically.
- Reset asserted mid-operation: immediate return to ZERO values. No arrived or fault pulse.
- jump_position holds the latched target in every state; it is only consumed in JUMP.

Decomposition:
- Package nav_pkg:
  - Velocity mode constants: MODE_ZERO=4'b0001, MODE_ATTACK=4'b0010, MODE_DEFENSE=4'b0100, MODE_STEALTH=4'b1000.
  - Position mode constants: POS_RESET=4'b0001, POS_NORMAL=4'b0010, POS_JUMP=4'b0100.
  - State encoding and axis slice macros X/Y/Z.
- Sub-module nav_axis_step, instanced 3 times. Inputs: target, pos, MAX_STEP. Outputs: signed step, dist, at_target. Purely combinational.
- The FSM and latches live in the top.

Test Plan:
1. Reset release -> one ZERO cycle with pos_mode=0001, then IDLE with tgt_ready=1 and Position output (0,0,0).
2. From (0,0,0), target X=5, Y=3, Z=0, jump_en=0:
   - Cycle 1: speed (4,3,0).
   - Cycle 2: speed (1,0,0).
   - Then speed 0 and arrived pulses. Position ends at (5,3,0); CRUISE lasts 3 cycles.
3. From (5,3,0), target (100,100,100), jump_en=1 -> PLAN, then JUMP with pos_mode=0100 and jump_position=(100,100,100), then SETTLE matches, arrived pulses. Total 4 cycles from the handshake.
4. From (100,100,100), target (98,100,100) -> speed X=16'hFFFE for one cycle, position X=98, arrived. Separately, from X=1 target X=16'hFFFF -> step 16'hFFFE (wrap path), arrived.
5. TIMEOUT=3, MAX_STEP=1, target X=10 -> 3 CRUISE steps, then fault pulses and state returns to IDLE with position X=3. abort asserted in cycle 2 of a cruise -> speed=0 that cycle, fault pulses, IDLE.
6. tgt_valid held during CRUISE with a second target -> not accepted (tgt_ready=0). It is accepted on the first IDLE cycle after arrived. rst_n asserted mid-CRUISE -> ZERO immediately, no pulses.
